// File: rtl/slot_pkg.sv
// Shared types and constants for the MSX slot-bus sequencer.
package slot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_STROBE  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_DRIVE   = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam int DEF_HOLD_MAX = 255;
  localparam int DEF_SETTLE   = 2;

  // Expansion-slot register sits on requester 0 and therefore has top priority.
  localparam int SLOT_REG_IDX = 0;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous pin; clears to RST_VAL on reset.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= {STAGES{RST_VAL}};
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/slot_bus_ctrl.sv
// Z80 bus-cycle sequencer: qualifies each cartridge-edge cycle, strobes the
// slot-side requesters once, and arbitrates their read data onto the bus.
module slot_bus_ctrl
  import slot_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = DEF_SETTLE,
  parameter int HOLD_MAX    = DEF_HOLD_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bus_rd_n,
  input  logic              bus_wr_n,
  input  logic              bus_sltsl_n,
  input  logic              bus_iorq_n,
  output logic              cyc_enable,
  output logic              cyc_rd,
  output logic              cyc_wr,
  output logic              cyc_io,
  input  logic [NREQ-1:0]   req_busreq,
  input  logic [8*NREQ-1:0] req_cdout,
  output logic [7:0]        bus_dout,
  output logic              bus_oe,
  output logic [NREQ-1:0]   bus_grant,
  output logic              busy,
  output logic              timeout_flag,
  output logic              collision
);

  logic [3:0] pins_n;
  logic [3:0] sync_n;
  logic [3:0] vec;
  logic [3:0] vec_snap;
  logic       s_rd, s_wr, s_mem, s_io, act;

  assign pins_n = {bus_iorq_n, bus_sltsl_n, bus_wr_n, bus_rd_n};

  // Pins are active low, so the synchronisers idle (and reset) high.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pins_n[gi]),
        .q       (sync_n[gi])
      );
    end
  endgenerate

  assign vec = ~sync_n;
  assign {s_io, s_mem, s_wr, s_rd} = vec;
  assign act = (s_rd | s_wr) & (s_mem | s_io);

  state_t          state_reg, state_next;
  logic [7:0]      settle_cnt, hold_cnt;
  logic [NREQ-1:0] win_grant;
  logic [7:0]      win_byte;
  logic            any_req, multi_req;

  assign any_req   = |req_busreq;
  assign multi_req = |(req_busreq & (req_busreq - NREQ'(1)));

  // Walk downwards so the lowest set index is the one left standing.
  always_comb begin
    win_grant = '0;
    win_byte  = 8'h00;
    for (int i = NREQ - 1; i >= SLOT_REG_IDX; i--) begin
      if (req_busreq[i]) begin
        win_grant    = '0;
        win_grant[i] = 1'b1;
        win_byte     = req_cdout[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (act) state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (vec != vec_snap)                  state_next = ST_IDLE;
        else if (settle_cnt == 8'(SETTLE - 1)) state_next = ST_STROBE;
      end
      ST_STROBE:  state_next = ST_COLLECT;
      ST_COLLECT: state_next = (cyc_rd && any_req) ? ST_DRIVE : ST_RECOVER;
      ST_DRIVE:   if (!s_rd || hold_cnt == 8'(HOLD_MAX - 1)) state_next = ST_RECOVER;
      ST_RECOVER: if (!s_rd && !s_wr) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      vec_snap     <= 4'h0;
      settle_cnt   <= 8'd0;
      hold_cnt     <= 8'd0;
      cyc_rd       <= 1'b0;
      cyc_wr       <= 1'b0;
      cyc_io       <= 1'b0;
      bus_dout     <= 8'h00;
      bus_grant    <= '0;
      timeout_flag <= 1'b0;
      collision    <= 1'b0;
    end else begin
      state_reg <= state_next;
      collision <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          settle_cnt <= 8'd0;
          vec_snap   <= vec;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          // Qualifiers are valid during the strobe itself; write beats read, io beats mem.
          if (state_next == ST_STROBE) begin
            cyc_wr <= s_wr;
            cyc_rd <= s_rd & ~s_wr;
            cyc_io <= s_io;
          end
        end
        ST_COLLECT: begin
          collision <= multi_req;
          hold_cnt  <= 8'd0;
          if (state_next == ST_DRIVE) begin
            bus_grant <= win_grant;
            bus_dout  <= win_byte;
          end
        end
        ST_DRIVE: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (state_next == ST_RECOVER) begin
            bus_grant <= '0;
            if (s_rd) timeout_flag <= 1'b1;
          end
        end
        ST_RECOVER: begin
          if (state_next == ST_IDLE) begin
            cyc_rd <= 1'b0;
            cyc_wr <= 1'b0;
            cyc_io <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cyc_enable = (state_reg == ST_STROBE);
  assign bus_oe     = (state_reg == ST_DRIVE);
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_slot_bus_ctrl.sv
// Self-checking bench for slot_bus_ctrl: directed and random bus cycles checked
// against timing rules computed from pin-hold lengths.
module tb_slot_bus_ctrl;

  localparam int NREQ      = 4;
  localparam int SYNC      = 2;
  localparam int SETTLE    = 2;
  localparam int HOLD_MAX  = 255;
  // Edge index (sampling edge = 1) after which the strobe / bus_oe are first seen.
  localparam int STROBE_AT = SYNC + SETTLE + 1;
  localparam int OE_AT     = STROBE_AT + 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              bus_rd_n, bus_wr_n, bus_sltsl_n, bus_iorq_n;
  logic              cyc_enable, cyc_rd, cyc_wr, cyc_io;
  logic [NREQ-1:0]   req_busreq;
  logic [8*NREQ-1:0] req_cdout;
  logic [7:0]        bus_dout;
  logic              bus_oe;
  logic [NREQ-1:0]   bus_grant;
  logic              busy, timeout_flag, collision;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_timeout = 1'b0;

  slot_bus_ctrl #(
    .NREQ(NREQ), .SYNC_STAGES(SYNC), .SETTLE(SETTLE), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus_rd_n     (bus_rd_n),
    .bus_wr_n     (bus_wr_n),
    .bus_sltsl_n  (bus_sltsl_n),
    .bus_iorq_n   (bus_iorq_n),
    .cyc_enable   (cyc_enable),
    .cyc_rd       (cyc_rd),
    .cyc_wr       (cyc_wr),
    .cyc_io       (cyc_io),
    .req_busreq   (req_busreq),
    .req_cdout    (req_cdout),
    .bus_dout     (bus_dout),
    .bus_oe       (bus_oe),
    .bus_grant    (bus_grant),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .collision    (collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".cyc_enable"}, cyc_enable, 0);
    chk({tag, ".cyc_rd"}, cyc_rd, 0);
    chk({tag, ".cyc_wr"}, cyc_wr, 0);
    chk({tag, ".cyc_io"}, cyc_io, 0);
    chk({tag, ".bus_oe"}, bus_oe, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".timeout"}, timeout_flag, 0);
    chk({tag, ".collision"}, collision, 0);
    chk({tag, ".bus_dout"}, bus_dout, 0);
    chk({tag, ".bus_grant"}, bus_grant, 0);
  endtask

  // One CPU cycle: the chosen pins are low before edges 1..len, then idle.
  task automatic run_txn(input string name, input int len, input bit rd, input bit wr,
                         input bit mem, input bit io, input logic [3:0] breq,
                         input logic [31:0] data);
    bit         strobe_exp, drive_exp;
    logic [3:0] g_exp;
    logic [7:0] d_exp;
    int         span, oe_exp;
    int         strobes = 0, strobe_cyc = -1, oe_cnt = 0, oe_first = -1;
    int         col_cnt = 0, busy_cnt = 0, drive_bad = 0;
    logic       q_rd = 1'b0, q_wr = 1'b0, q_io = 1'b0;

    strobe_exp = (len >= SETTLE + 1);
    drive_exp  = strobe_exp && rd && !wr && (breq != 4'd0);
    g_exp      = drive_exp ? (breq & (~breq + 4'd1)) : 4'd0;
    d_exp      = 8'h00;
    for (int i = 0; i < NREQ; i++) if (g_exp[i]) d_exp = data[8*i +: 8];
    span   = len + SYNC - OE_AT + 1;
    oe_exp = !drive_exp ? 0 : (span < 1 ? 1 : (span > HOLD_MAX ? HOLD_MAX : span));
    if (drive_exp && span > HOLD_MAX) exp_timeout = 1'b1;

    req_cdout = data;
    for (int c = 1; c <= len + 12; c++) begin
      bus_rd_n    = !(rd  && c <= len);
      bus_wr_n    = !(wr  && c <= len);
      bus_sltsl_n = !(mem && c <= len);
      bus_iorq_n  = !(io  && c <= len);
      @(posedge clk); #1;
      if (cyc_enable) begin
        strobes++;
        strobe_cyc = c;
        q_rd = cyc_rd; q_wr = cyc_wr; q_io = cyc_io;
        req_busreq = breq;  // requester answers the cycle after its enable
      end
      if (bus_oe) begin
        if (oe_first < 0) oe_first = c;
        oe_cnt++;
        if (bus_dout !== d_exp || bus_grant !== g_exp) drive_bad++;
      end
      if (collision) col_cnt++;
      if (busy) busy_cnt++;
    end
    req_busreq = '0;

    chk({name, ".strobes"}, strobes, strobe_exp);
    if (strobe_exp) begin
      chk({name, ".strobe_cycle"}, strobe_cyc, STROBE_AT);
      chk({name, ".cyc_rd"}, q_rd, rd && !wr);
      chk({name, ".cyc_wr"}, q_wr, wr);
      chk({name, ".cyc_io"}, q_io, io);
    end else begin
      chk({name, ".glitch_busy_le3"}, busy_cnt <= 3, 1);
    end
    chk({name, ".oe_cycles"}, oe_cnt, oe_exp);
    if (drive_exp) begin
      chk({name, ".oe_first"}, oe_first, OE_AT);
      chk({name, ".drive_data_grant_bad"}, drive_bad, 0);
    end
    chk({name, ".collision_pulses"}, col_cnt, strobe_exp && ($countones(breq) > 1));
    chk({name, ".timeout_flag"}, timeout_flag, exp_timeout);
    chk({name, ".busy_end"}, busy, 0);
    chk({name, ".grant_end"}, bus_grant, 0);
    $display("txn %s len=%0d rd=%0d wr=%0d mem=%0d io=%0d breq=%b strobes=%0d oe_cycles=%0d",
             name, len, rd, wr, mem, io, breq, strobes, oe_cnt);
  endtask

  initial begin
    bit   seen;
    int   sel_rw, sel_mi;
    reset_n     = 1'b0;
    bus_rd_n    = 1'b1;
    bus_wr_n    = 1'b1;
    bus_sltsl_n = 1'b1;
    bus_iorq_n  = 1'b1;
    req_busreq  = '0;
    req_cdout   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_txn("mem_read",  12, 1, 0, 1, 0, 4'b0001, 32'h0000_005A);
    run_txn("mem_write", 10, 0, 1, 1, 0, 4'b0001, 32'h1234_5678);
    run_txn("collision", 12, 1, 0, 1, 0, 4'b1010, 32'h3300_1100);
    run_txn("glitch",     2, 1, 0, 1, 0, 4'b0001, 32'hDEAD_BEEF);
    run_txn("rd_and_wr",  8, 1, 1, 1, 0, 4'b0011, 32'hCAFE_F00D);
    run_txn("mem_and_io", 9, 1, 0, 1, 1, 4'b0100, 32'h00AB_0000);
    run_txn("min_strobe", SETTLE + 1, 1, 0, 0, 1, 4'b1000, 32'h7700_0000);

    for (int t = 0; t < 30; t++) begin
      sel_rw = $urandom_range(0, 2);
      sel_mi = $urandom_range(0, 2);
      run_txn($sformatf("rand%0d", t), $urandom_range(1, 20),
              sel_rw != 1, sel_rw != 0, sel_mi != 1, sel_mi != 0,
              4'($urandom_range(0, 15)), $urandom);
    end

    run_txn("stuck_read", 400, 1, 0, 1, 0, 4'b0001, 32'h0000_00C3);
    run_txn("after_stuck", 12, 1, 0, 0, 1, 4'b0110, 32'h4455_6677);

    // Reset asserted while the bus is being driven.
    req_cdout   = 32'hA5A5_A5A5;
    bus_rd_n    = 1'b0;
    bus_sltsl_n = 1'b0;
    seen        = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (cyc_enable) req_busreq = 4'b0001;
      if (bus_oe) seen = 1'b1;
    end
    chk("rst_mid.reached_drive", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid.bus_oe_async", bus_oe, 0);
    chk("rst_mid.grant_async", bus_grant, 0);
    chk("rst_mid.busy_async", busy, 0);
    bus_rd_n    = 1'b1;
    bus_sltsl_n = 1'b1;
    req_busreq  = '0;
    exp_timeout = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (cyc_enable || busy) seen = 1'b1;
    end
    chk("rst_mid.no_activity_after", seen, 0);
    check_reset_values("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slot_bus_ctrl.md
# slot_bus_ctrl

Bus-cycle sequencer and read-data arbiter sitting between the asynchronous MSX cartridge-edge control pins and the slot-side peripherals: the expansion-slot register and the subslot devices. It synchronises rd/wr/sltsl/iorq, qualifies each Z80 bus cycle, and issues exactly one `cyc_enable` strobe per cycle. It then collects `busreq`/`cdout` from up to NREQ requesters, grants one by fixed priority, and drives the data-bus output enable until the CPU ends the read.

## Interface
- NREQ, 4, number of read-data requesters (1..8)
- SYNC_STAGES, 2, synchroniser flops per control input (≥2)
- SETTLE, 2, cycles the qualified cycle must stay stable before the strobe (≥1)
- HOLD_MAX, 255, maximum DRIVE cycles before forced release (8-bit counter)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- bus_rd_n, bus_wr_n, bus_sltsl_n, bus_iorq_n  in  1 each  raw async edge pins, active low
- cyc_enable  out  1  one-clock strobe per qualified cycle; drives requesters' `enable`
- cyc_rd, cyc_wr, cyc_io  out  1 each  cycle qualifiers, valid while cyc_enable=1, held until RECOVER exits
- req_busreq  in  NREQ  per-requester "I have read data" flags
- req_cdout  in  8*NREQ  requester data; byte i = bits [8i+7:8i]
- bus_dout  out  8  granted data byte
- bus_oe  out  1  data-bus driver enable / busdir
- bus_grant  out  NREQ  one-hot grant, held through DRIVE
- busy  out  1  FSM not IDLE
- timeout_flag  out  1  sticky; set on HOLD_MAX expiry, cleared only by reset
- collision  out  1  one-clock pulse when more than one req_busreq bit is set at COLLECT

## Operation
- Synchronised signals are `s_rd`, `s_wr`, `s_mem` (sltsl low), `s_io` (iorq low); all are active high internally.
- `act` = (s_rd|s_wr) & (s_mem|s_io).
- FSM states and transitions:
  - IDLE: act=1 → SETTLE; clear the settle counter.
  - SETTLE: count while act is stable and the {rd,wr,mem,io} vector is unchanged. Any change → IDLE. Count reaches SETTLE → STROBE.
  - STROBE: cyc_enable=1 for exactly one cycle; latch the qualifiers → COLLECT.
  - COLLECT: requesters register busreq one cycle after enable; sample req_busreq this cycle. The lowest set index wins; latch its byte into bus_dout and set bus_grant. If cyc_rd and any busreq → DRIVE, else → RECOVER.
  - DRIVE: bus_oe=1; the hold counter increments. s_rd=0 → RECOVER. Counter reaches HOLD_MAX → set timeout_flag, → RECOVER.
  - RECOVER: bus_oe=0, bus_grant=0. Wait for s_rd=0 and s_wr=0 → IDLE. This guarantees no second strobe within one CPU cycle.
- Simultaneous rd and wr: write wins; cyc_wr=1, cyc_rd=0, and no DRIVE.
- Simultaneous mem and io: io wins; cyc_io=1.
- Write cycles, or reads with no busreq, never assert bus_oe.
- Reset mid-operation: bus_oe and all other outputs drop asynchronously; the FSM returns to IDLE; synchroniser flops clear to the deasserted level.

## Timing
- Reset values: cyc_enable, cyc_rd, cyc_wr, cyc_io, bus_oe, busy, timeout_flag, collision = 0; bus_dout = 8'h00; bus_grant = 0.
- A pin asserted before edge k reaches the internal signal at edge k+SYNC_STAGES−1. Strobe is high in cycle k+SYNC_STAGES+SETTLE, i.e. 5 cycles after the sampling edge with defaults.
- COLLECT is the cycle after STROBE. bus_oe rises in the following cycle, at strobe+2.
- bus_oe falls SYNC_STAGES+1 cycles after the rd pin deasserts.
- bus_dout is stable for the whole time bus_oe=1; it is not updated in DRIVE.
- Minimum IDLE→IDLE cycle length is SETTLE+3 cycles.

## Structure
- Shared package `slot_pkg` holds:
  - the FSM state enum (IDLE, SETTLE, STROBE, COLLECT, DRIVE, RECOVER);
  - the default HOLD_MAX and SETTLE constants;
  - the requester index of the expansion-slot register (0, highest priority).
- Sub-module `sync_ff` (SYNC_STAGES-deep, parameterised reset level) is instantiated once per control pin.
- Priority encoder and counters stay inline.

## Test plan
- Memory read, defaults: sltsl/rd low for 12 cycles, req_busreq=4'b0001 at strobe+1, byte0=8'h5A → one cyc_enable at cycle 5, bus_oe high from cycle 7, bus_dout=8'h5A, bus_grant=0001, bus_oe drops 3 cycles after rd rises.
- Write: sltsl/wr low 10 cycles → one strobe with cyc_wr=1, bus_oe never asserts, busy returns to 0 after wr rises.
- Collision: req_busreq=4'b1010, bytes 8'h11/8'h33 → grant=0010, bus_dout=8'h11, collision pulse of 1 cycle.
- Glitch: rd low for 2 cycles only → no strobe, FSM back to IDLE, busy ≤3 cycles.
- Stuck read: rd held low 400 cycles with busreq → bus_oe released after 255 DRIVE cycles, timeout_flag=1 sticky, no second strobe until rd rises.
- Reset in DRIVE: reset_n low mid-read → bus_oe=0 in same cycle (async); after release with pins idle, all outputs are at reset values.
